// File: rtl/img2col_pkg.sv
// Shared types and defaults for the img2col pixel fetch path: geometry,
// beat phase, the sideband that travels with each SRAM read, and the slot helper.
package img2col_pkg;

  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;
  localparam int DEF_K      = 5;
  localparam int DEF_NUM_PU = 28;

  typedef enum logic {
    BUFFERING = 1'b0,
    WORKING   = 1'b1
  } phase_t;

  typedef struct packed {
    logic [4:0] pu;
    logic [2:0] tap;
    logic [2:0] slot;
    logic       row_last;
    logic       frame_last;
  } sideband_t;

  // Line-buffer slot that holds image row r.
  function automatic logic [2:0] slot_of(input logic [6:0] r, input int k);
    logic [6:0] m;
    m = r % 7'(k);
    return m[2:0];
  endfunction

endpackage

// File: rtl/img2col_sb_delay.sv
// Valid + sideband delay line that keeps beat metadata aligned with the
// SRAM read return; flush drops every entry in one cycle.
module img2col_sb_delay
  import img2col_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      flush,
  input  logic      in_valid,
  input  sideband_t in_sb,
  output logic      out_valid,
  output sideband_t out_sb
);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic      valid_reg;
    sideband_t sb_reg;
    logic      valid_in;
    sideband_t sb_in;

    if (gi == 0) begin : g_head
      assign valid_in = in_valid;
      assign sb_in    = in_sb;
    end else begin : g_link
      assign valid_in = g_stage[gi-1].valid_reg;
      assign sb_in    = g_stage[gi-1].sb_reg;
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        valid_reg <= 1'b0;
        sb_reg    <= '0;
      end else begin
        valid_reg <= valid_in && !flush;
        sb_reg    <= sb_in;
      end
    end
  end

  assign out_valid = g_stage[DEPTH-1].valid_reg;
  assign out_sb    = g_stage[DEPTH-1].sb_reg;

endmodule

// File: rtl/img2col_pixel_fetch.sv
// Turns img2col controller beats into input-image SRAM reads and forwards each
// returned pixel, tagged with PU/tap/slot, to the PU operand register files.
module img2col_pixel_fetch
  import img2col_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int NUM_PU = DEF_NUM_PU,
  parameter int DW     = 8,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear,
  input  logic          map_valid,
  input  logic          map_phase,
  input  logic [5:0]    round,
  input  logic [5:0]    row_no,
  input  logic [5:0]    pu_no,
  input  logic [5:0]    pu1_add,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          pe_we,
  output logic [4:0]    pe_pu,
  output logic [2:0]    pe_tap,
  output logic [2:0]    pe_slot,
  output logic [DW-1:0] pe_data,
  output logic          row_done,
  output logic          frame_done,
  output logic          range_err
);

  phase_t    phase;
  logic [6:0] row;
  logic [6:0] col;
  logic [AW-1:0] addr_next;
  logic      legal;
  logic      issue;
  logic      err_set;
  sideband_t sb_next;

  always_comb begin
    phase     = phase_t'(map_phase);
    // Working rounds read K rows ahead of the round number.
    row       = (phase == WORKING) ? ({1'b0, round} + 7'(K)) : {1'b0, row_no};
    col       = {1'b0, pu_no} + {1'b0, pu1_add};
    addr_next = AW'(row) * AW'(IMG_W) + AW'(col);
    legal     = (pu_no < 6'(NUM_PU)) && (pu1_add < 6'(K)) &&
                !((phase == BUFFERING) && (row_no >= 6'(K)));
    // Out-of-image rows are legal filler beats: no read, no error.
    issue     = map_valid && !clear && legal && (row < 7'(IMG_H));
    err_set   = map_valid && !clear && !legal;

    sb_next.pu         = pu_no[4:0];
    sb_next.tap        = pu1_add[2:0];
    sb_next.slot       = slot_of(row, K);
    sb_next.row_last   = (pu_no == 6'(NUM_PU - 1)) && (pu1_add == 6'(K - 1));
    sb_next.frame_last = sb_next.row_last && (row == 7'(IMG_H - 1));
  end

  logic          mem_re_reg;
  logic [AW-1:0] mem_addr_reg;
  sideband_t     iss_sb_reg;
  logic          range_err_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_re_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      iss_sb_reg    <= '0;
      range_err_reg <= 1'b0;
    end else begin
      mem_re_reg <= issue;
      if (issue) begin
        mem_addr_reg <= addr_next;
        iss_sb_reg   <= sb_next;
      end
      if (clear) begin
        range_err_reg <= 1'b0;
      end else if (err_set) begin
        range_err_reg <= 1'b1;
      end
    end
  end

  logic      dly_valid;
  sideband_t dly_sb;

  img2col_sb_delay #(
    .DEPTH(RD_LAT)
  ) u_sb_delay (
    .clk      (clk),
    .nrst     (nrst),
    .flush    (clear),
    .in_valid (mem_re_reg),
    .in_sb    (iss_sb_reg),
    .out_valid(dly_valid),
    .out_sb   (dly_sb)
  );

  logic          take;
  logic          pe_we_reg;
  logic [4:0]    pe_pu_reg;
  logic [2:0]    pe_tap_reg;
  logic [2:0]    pe_slot_reg;
  logic [DW-1:0] pe_data_reg;
  logic          row_done_reg;
  logic          frame_done_reg;

  // clear also kills the entry that is leaving the delay line this cycle.
  assign take = dly_valid && !clear;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pe_we_reg      <= 1'b0;
      pe_pu_reg      <= '0;
      pe_tap_reg     <= '0;
      pe_slot_reg    <= '0;
      pe_data_reg    <= '0;
      row_done_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      pe_we_reg      <= take;
      row_done_reg   <= take && dly_sb.row_last;
      frame_done_reg <= take && dly_sb.frame_last;
      if (take) begin
        pe_pu_reg   <= dly_sb.pu;
        pe_tap_reg  <= dly_sb.tap;
        pe_slot_reg <= dly_sb.slot;
        pe_data_reg <= mem_rdata;
      end
    end
  end

  assign mem_re     = mem_re_reg;
  assign mem_addr   = mem_addr_reg;
  assign pe_we      = pe_we_reg;
  assign pe_pu      = pe_pu_reg;
  assign pe_tap     = pe_tap_reg;
  assign pe_slot    = pe_slot_reg;
  assign pe_data    = pe_data_reg;
  assign row_done   = row_done_reg;
  assign frame_done = frame_done_reg;
  assign range_err  = range_err_reg;

endmodule

// File: tb/tb_img2col_pixel_fetch.sv
// Directed scoreboard bench for img2col_pixel_fetch; two instances (RD_LAT 1 and 3)
// share one stimulus stream, each backed by its own SRAM latency model.
module tb_img2col_pixel_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst = 1'b0;
  logic       clear = 1'b0;
  logic       map_valid = 1'b0;
  logic       map_phase = 1'b0;
  logic [5:0] round = '0;
  logic [5:0] row_no = '0;
  logic [5:0] pu_no = '0;
  logic [5:0] pu1_add = '0;

  logic       mem_re_o     [2];
  logic [9:0] mem_addr_o   [2];
  logic       pe_we_o      [2];
  logic [4:0] pe_pu_o      [2];
  logic [2:0] pe_tap_o     [2];
  logic [2:0] pe_slot_o    [2];
  logic [7:0] pe_data_o    [2];
  logic       row_done_o   [2];
  logic       frame_done_o [2];
  logic       range_err_o  [2];

  logic [7:0] mem [1024];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [7:0] pipe [LAT];

    img2col_pixel_fetch #(.RD_LAT(LAT)) u_dut (
      .clk(clk), .nrst(nrst), .clear(clear), .map_valid(map_valid),
      .map_phase(map_phase), .round(round), .row_no(row_no), .pu_no(pu_no),
      .pu1_add(pu1_add), .mem_re(mem_re_o[gi]), .mem_addr(mem_addr_o[gi]),
      .mem_rdata(pipe[LAT-1]), .pe_we(pe_we_o[gi]), .pe_pu(pe_pu_o[gi]),
      .pe_tap(pe_tap_o[gi]), .pe_slot(pe_slot_o[gi]), .pe_data(pe_data_o[gi]),
      .row_done(row_done_o[gi]), .frame_done(frame_done_o[gi]),
      .range_err(range_err_o[gi])
    );

    always @(posedge clk) begin
      if (mem_re_o[gi]) pipe[0] <= mem[mem_addr_o[gi]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  typedef struct {
    int         cyc;
    logic [9:0] addr;
  } rd_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [4:0] pu;
    logic [2:0] tap;
    logic [2:0] slot;
    logic       rd;
    logic       fd;
  } pe_exp_t;

  rd_exp_t aq0[$], aq1[$];
  pe_exp_t pq0[$], pq1[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pe_cnt [2];
  int rd_cnt [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d);
    rd_exp_t re;
    pe_exp_t pe;
    logic    exp_re;
    logic    exp_we;
    if (d == 0) exp_re = (aq0.size() > 0) && (aq0[0].cyc == cyc);
    else        exp_re = (aq1.size() > 0) && (aq1[0].cyc == cyc);
    chk($sformatf("mem_re[%0d]@%0d", d, cyc), 32'(mem_re_o[d]), 32'(exp_re));
    if (exp_re) begin
      if (d == 0) re = aq0.pop_front();
      else        re = aq1.pop_front();
      chk($sformatf("mem_addr[%0d]@%0d", d, cyc), 32'(mem_addr_o[d]), 32'(re.addr));
    end
    if (d == 0) exp_we = (pq0.size() > 0) && (pq0[0].cyc == cyc);
    else        exp_we = (pq1.size() > 0) && (pq1[0].cyc == cyc);
    chk($sformatf("pe_we[%0d]@%0d", d, cyc), 32'(pe_we_o[d]), 32'(exp_we));
    if (pe_we_o[d] === 1'b1) pe_cnt[d]++;
    if (row_done_o[d] === 1'b1) rd_cnt[d]++;
    if (exp_we) begin
      if (d == 0) pe = pq0.pop_front();
      else        pe = pq1.pop_front();
      chk($sformatf("pe_data[%0d]@%0d", d, cyc), 32'(pe_data_o[d]), 32'(pe.data));
      chk($sformatf("pe_pu[%0d]@%0d", d, cyc), 32'(pe_pu_o[d]), 32'(pe.pu));
      chk($sformatf("pe_tap[%0d]@%0d", d, cyc), 32'(pe_tap_o[d]), 32'(pe.tap));
      chk($sformatf("pe_slot[%0d]@%0d", d, cyc), 32'(pe_slot_o[d]), 32'(pe.slot));
      chk($sformatf("row_done[%0d]@%0d", d, cyc), 32'(row_done_o[d]), 32'(pe.rd));
      chk($sformatf("frame_done[%0d]@%0d", d, cyc), 32'(frame_done_o[d]), 32'(pe.fd));
    end else begin
      chk($sformatf("row_done_idle[%0d]@%0d", d, cyc), 32'(row_done_o[d]), 32'd0);
      chk($sformatf("frame_done_idle[%0d]@%0d", d, cyc), 32'(frame_done_o[d]), 32'd0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mon(0);
    mon(1);
    map_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic beat(input logic ph, input int rnd, input int row, input int pu,
                      input int add, input logic clr);
    int      r;
    logic    legal;
    logic [9:0] a;
    rd_exp_t re;
    pe_exp_t pe;
    @(negedge clk);
    mon(0);
    mon(1);
    map_valid = 1'b1;
    map_phase = ph;
    round     = 6'(rnd);
    row_no    = 6'(row);
    pu_no     = 6'(pu);
    pu1_add   = 6'(add);
    clear     = clr;
    r     = ph ? rnd + 5 : row;
    legal = (pu < 28) && (add < 5) && !(!ph && row >= 5);
    if (!clr && legal && r < 32) begin
      a        = 10'(r * 32 + pu + add);
      re.addr  = a;
      pe.data  = mem[a];
      pe.pu    = 5'(pu);
      pe.tap   = 3'(add);
      pe.slot  = 3'(r % 5);
      pe.rd    = (pu == 27) && (add == 4);
      pe.fd    = pe.rd && (r == 31);
      re.cyc   = cyc + 1;
      pe.cyc   = cyc + 2 + lat_of(0);
      aq0.push_back(re);
      pq0.push_back(pe);
      pe.cyc   = cyc + 2 + lat_of(1);
      aq1.push_back(re);
      pq1.push_back(pe);
    end
  endtask

  task automatic flush_sb();
    aq0.delete();
    aq1.delete();
    pq0.delete();
    pq1.delete();
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s mem_re[%0d]", tag, d), 32'(mem_re_o[d]), 32'd0);
      chk($sformatf("%s mem_addr[%0d]", tag, d), 32'(mem_addr_o[d]), 32'd0);
      chk($sformatf("%s pe_we[%0d]", tag, d), 32'(pe_we_o[d]), 32'd0);
      chk($sformatf("%s pe_pu[%0d]", tag, d), 32'(pe_pu_o[d]), 32'd0);
      chk($sformatf("%s pe_tap[%0d]", tag, d), 32'(pe_tap_o[d]), 32'd0);
      chk($sformatf("%s pe_slot[%0d]", tag, d), 32'(pe_slot_o[d]), 32'd0);
      chk($sformatf("%s pe_data[%0d]", tag, d), 32'(pe_data_o[d]), 32'd0);
      chk($sformatf("%s row_done[%0d]", tag, d), 32'(row_done_o[d]), 32'd0);
      chk($sformatf("%s frame_done[%0d]", tag, d), 32'(frame_done_o[d]), 32'd0);
      chk($sformatf("%s range_err[%0d]", tag, d), 32'(range_err_o[d]), 32'd0);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s range_err[%0d]", tag, d), 32'(range_err_o[d]), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[71] = 8'hA5;
    for (int d = 0; d < 2; d++) begin
      pe_cnt[d] = 0;
      rd_cnt[d] = 0;
    end

    repeat (3) idle();
    chk_reset("reset");
    nrst = 1'b1;
    idle();

    // Buffering beat: row 2, PU 3, tap 4 -> address 71
    beat(1'b0, 0, 2, 3, 4, 1'b0);
    repeat (6) idle();

    // Working round 0 -> row 5; round 27 -> row 32, suppressed without error
    beat(1'b1, 0, 0, 0, 0, 1'b0);
    beat(1'b1, 27, 0, 5, 2, 1'b0);
    repeat (6) idle();
    chk_err("suppressed", 1'b0);

    // Last pixel of the frame
    beat(1'b1, 26, 0, 27, 4, 1'b0);
    repeat (6) idle();

    // Illegal PU, tap and buffering row; row_no ignored when working
    beat(1'b0, 0, 0, 28, 0, 1'b0);
    idle();
    chk_err("illegal_pu t+1", 1'b1);
    repeat (3) idle();
    chk_err("illegal_pu held", 1'b1);
    beat(1'b0, 0, 0, 0, 0, 1'b1);
    idle();
    chk_err("after clear", 1'b0);
    beat(1'b0, 0, 1, 2, 5, 1'b0);
    idle();
    chk_err("illegal_tap", 1'b1);
    beat(1'b0, 0, 0, 0, 0, 1'b1);
    beat(1'b0, 0, 5, 2, 1, 1'b0);
    idle();
    chk_err("illegal_row", 1'b1);
    beat(1'b0, 0, 0, 0, 0, 1'b1);
    beat(1'b1, 10, 9, 4, 3, 1'b0);
    repeat (6) idle();
    chk_err("working_row_no", 1'b0);

    // Full 140-beat row stream, buffering row 3
    for (int d = 0; d < 2; d++) begin
      pe_cnt[d] = 0;
      rd_cnt[d] = 0;
    end
    for (int p = 0; p < 28; p++)
      for (int k = 0; k < 5; k++)
        beat(1'b0, 0, 3, p, k, 1'b0);
    repeat (8) idle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stream pe_cnt[%0d]", d), 32'(pe_cnt[d]), 32'd140);
      chk($sformatf("stream rd_cnt[%0d]", d), 32'(rd_cnt[d]), 32'd1);
    end

    // Reset mid-stream, with range_err set beforehand
    beat(1'b0, 0, 0, 31, 0, 1'b0);
    for (int i = 0; i < 6; i++) beat(1'b0, 0, 4, i, 1, 1'b0);
    chk_err("pre_reset", 1'b1);
    #2;
    nrst      = 1'b0;
    map_valid = 1'b0;
    flush_sb();
    idle();
    idle();
    chk_reset("mid_reset");
    nrst = 1'b1;
    beat(1'b0, 0, 1, 5, 2, 1'b0);
    repeat (7) idle();

    // clear with a simultaneous beat, in-flight beats killed
    for (int i = 0; i < 4; i++) beat(1'b0, 0, 1, i, 1, 1'b0);
    beat(1'b0, 0, 1, 10, 2, 1'b1);
    @(posedge clk);
    #1;
    flush_sb();
    repeat (7) idle();
    beat(1'b0, 0, 0, 40, 0, 1'b1);
    idle();
    chk_err("clear_wins_illegal", 1'b0);
    beat(1'b1, 3, 0, 20, 3, 1'b0);
    repeat (7) idle();

    chk("pending aq0", 32'(aq0.size()), 32'd0);
    chk("pending aq1", 32'(aq1.size()), 32'd0);
    chk("pending pq0", 32'(pq0.size()), 32'd0);
    chk("pending pq1", 32'(pq1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
